// File: rtl/dm_sba_mem_responder.sv
// SBA bus responder: req/gnt slave backed by a byte-enabled word memory,
// with configurable grant and response latency for wait-state testing.
module dm_sba_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned GNT_DELAY = 0,
  parameter int unsigned RESP_LAT  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slave_req_i,
  input  logic [31:0] slave_add_i,
  input  logic        slave_we_i,
  input  logic [31:0] slave_wdata_i,
  input  logic [3:0]  slave_be_i,
  output logic        slave_gnt_o,
  output logic        slave_r_valid_o,
  output logic        slave_r_err_o,
  output logic        slave_r_other_err_o,
  output logic [31:0] slave_r_rdata_o
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LIMIT     = 33'(MEM_WORDS * 4);
  localparam logic [3:0]  GNT_LAST  = 4'(GNT_DELAY - 1);
  localparam logic [3:0]  RESP_LAST = 4'(RESP_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GNT, S_RESP} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic resp_done;

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;
  logic        err_q, oerr_q;

  logic [32:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  // 33-bit subtraction: a borrow into bit 32 marks addresses below the base.
  assign offset   = {1'b0, slave_add_i} - {1'b0, ADDR_BASE};
  assign in_range = !offset[32] && (offset < LIMIT);
  assign idx      = offset[IDX_W+1:2];

  assign resp_done = (state_q == S_RESP) && (cnt_q == RESP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (slave_req_i) state_d = (GNT_DELAY == 0) ? S_GNT : S_WAIT;
      end
      S_WAIT: begin
        if (!slave_req_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GNT_LAST) begin
          state_d = S_GNT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GNT: begin
        state_d = S_RESP;
        cnt_d   = '0;
      end
      S_RESP: begin
        // The r_valid cycle behaves like IDLE so a new gnt can follow it directly.
        if (!resp_done) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (slave_req_i) state_d = (GNT_DELAY == 0) ? S_GNT : S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      oerr_q  <= 1'b0;
    end else if (state_q == S_GNT) begin
      err_q   <= !in_range;
      oerr_q  <= in_range && (slave_be_i == 4'b0000);
      rdata_q <= '0;
      if (in_range && (slave_be_i != 4'b0000)) begin
        if (slave_we_i) begin
          for (int unsigned n = 0; n < 4; n++) begin
            if (slave_be_i[n]) mem_q[idx][8*n +: 8] <= slave_wdata_i[8*n +: 8];
          end
        end else begin
          rdata_q <= mem_q[idx];
        end
      end
    end
  end

  assign slave_gnt_o         = (state_q == S_GNT);
  assign slave_r_valid_o     = resp_done;
  assign slave_r_err_o       = resp_done && err_q;
  assign slave_r_other_err_o = resp_done && oerr_q;
  assign slave_r_rdata_o     = resp_done ? rdata_q : '0;

endmodule

// File: tb/tb_dm_sba_mem_responder.sv
// Directed bench: a default-latency responder and a GNT_DELAY=3/RESP_LAT=4 one.
module tb_dm_sba_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        d_req, d_we, s_req, s_we;
  logic [31:0] d_add, d_wdata, s_add, s_wdata;
  logic [3:0]  d_be, s_be;
  logic        d_gnt, d_rv, d_err, d_oerr, s_gnt, s_rv, s_err, s_oerr;
  logic [31:0] d_rdata, s_rdata;

  dm_sba_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_req_i(d_req), .slave_add_i(d_add), .slave_we_i(d_we),
    .slave_wdata_i(d_wdata), .slave_be_i(d_be),
    .slave_gnt_o(d_gnt), .slave_r_valid_o(d_rv), .slave_r_err_o(d_err),
    .slave_r_other_err_o(d_oerr), .slave_r_rdata_o(d_rdata)
  );

  dm_sba_mem_responder #(.GNT_DELAY(3), .RESP_LAT(4)) dut_slow (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_req_i(s_req), .slave_add_i(s_add), .slave_we_i(s_we),
    .slave_wdata_i(s_wdata), .slave_be_i(s_be),
    .slave_gnt_o(s_gnt), .slave_r_valid_o(s_rv), .slave_r_err_o(s_err),
    .slave_r_other_err_o(s_oerr), .slave_r_rdata_o(s_rdata)
  );

  bit sel = 1'b0;
  logic        o_gnt, o_rv, o_err, o_oerr;
  logic [31:0] o_rdata;
  assign o_gnt   = sel ? s_gnt   : d_gnt;
  assign o_rv    = sel ? s_rv    : d_rv;
  assign o_err   = sel ? s_err   : d_err;
  assign o_oerr  = sel ? s_oerr  : d_oerr;
  assign o_rdata = sel ? s_rdata : d_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin
      s_req = req; s_we = we; s_add = a; s_wdata = wd; s_be = be;
    end else begin
      d_req = req; d_we = we; d_add = a; d_wdata = wd; d_be = be;
    end
  endtask

  // One bus transaction on the selected responder. gw/rw are the cycle counts
  // req->gnt and gnt->r_valid (-1 if never seen); gl flags any stray gnt or
  // nonzero response field outside the r_valid cycle.
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output int gw, output int rw,
                      output logic [31:0] rd, output logic er, output logic oe,
                      output bit gl);
    gl = 1'b0; gw = -1; rw = -1; rd = 'x; er = 1'bx; oe = 1'bx;
    drive(1'b1, we, a, wd, be);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_rv || o_err || o_oerr || (o_rdata != 32'd0)) gl = 1'b1;
      if (o_gnt) begin gw = k; break; end
    end
    drive(1'b0, we, a, wd, be);
    if (gw > 0) begin
      for (int m = 1; m <= 40; m++) begin
        @(negedge clk);
        if (o_gnt) gl = 1'b1;
        if (o_rv) begin
          rw = m; rd = o_rdata; er = o_err; oe = o_oerr;
          break;
        end
        if (o_err || o_oerr || (o_rdata != 32'd0)) gl = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({d_gnt, d_rv, d_err, d_oerr, d_rdata, s_gnt, s_rv, s_err, s_oerr, s_rdata} !== 72'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got d=%b%b%b%b/%h s=%b%b%b%b/%h want all 0",
               d_gnt, d_rv, d_err, d_oerr, d_rdata, s_gnt, s_rv, s_err, s_oerr, s_rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({d_gnt, d_rv, d_err, d_oerr, d_rdata, s_gnt, s_rv, s_err, s_oerr, s_rdata} !== 72'd0) begin
      n_bad++;
      $display("FAIL idle_outputs: got d=%b%b%b%b/%h s=%b%b%b%b/%h want all 0",
               d_gnt, d_rv, d_err, d_oerr, d_rdata, s_gnt, s_rv, s_err, s_oerr, s_rdata);
    end
  endtask

  task automatic test_write_read();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl;
    sel = 1'b0;
    xfer(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), er, oe, gl, rd} !== {8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL wr_1004: got gw=%0d rw=%0d err=%b oerr=%b glitch=%b rdata=%h want 1 1 0 0 0 00000000",
               gw, rw, er, oe, gl, rd);
    end
    xfer(1'b0, 32'h1004, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), er, oe, gl, rd} !== {8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL rd_1004: got gw=%0d rw=%0d err=%b oerr=%b glitch=%b rdata=%h want 1 1 0 0 0 deadbeef",
               gw, rw, er, oe, gl, rd);
    end
  endtask

  task automatic test_partial_write();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl;
    sel = 1'b0;
    xfer(1'b1, 32'h1004, 32'h11223344, 4'hF, gw, rw, rd, er, oe, gl);
    xfer(1'b1, 32'h1006, 32'h0000AA00, 4'b0010, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL partial_wr_resp: got err=%b oerr=%b rdata=%h want 0 0 00000000", er, oe, rd);
    end
    xfer(1'b0, 32'h1004, 32'h0, 4'b0001, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, gl, rd} !== {1'b0, 1'b0, 1'b0, 32'h1122AA44}) begin
      n_bad++;
      $display("FAIL partial_rd: got err=%b oerr=%b glitch=%b rdata=%h want 0 0 0 1122aa44", er, oe, gl, rd);
    end
  endtask

  task automatic test_range();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl;
    sel = 1'b0;
    xfer(1'b0, 32'h0FFC, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(rw), er, oe, rd} !== {8'd1, 1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rd_below_base: got rw=%0d err=%b oerr=%b rdata=%h want 1 1 0 00000000", rw, er, oe, rd);
    end
    xfer(1'b0, 32'h1400, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rd_past_end: got err=%b oerr=%b rdata=%h want 1 0 00000000", er, oe, rd);
    end
    xfer(1'b1, 32'h13FC, 32'hCAFEF00D, 4'hF, gw, rw, rd, er, oe, gl);
    xfer(1'b0, 32'h13FC, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b0, 1'b0, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL rd_last_word: got err=%b oerr=%b rdata=%h want 0 0 cafef00d", er, oe, rd);
    end
    xfer(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, gw, rw, rd, er, oe, gl);
    xfer(1'b1, 32'h1400, 32'h55555555, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe} !== 2'b10) begin
      n_bad++;
      $display("FAIL wr_past_end: got err=%b oerr=%b want 1 0", er, oe);
    end
    xfer(1'b0, 32'h1000, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'hA5A5A5A5}) begin
      n_bad++;
      $display("FAIL no_alias_word0: got err=%b rdata=%h want 0 a5a5a5a5", er, rd);
    end
    xfer(1'b0, 32'h1400, 32'h0, 4'h0, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL err_priority: got err=%b oerr=%b rdata=%h want 1 0 00000000", er, oe, rd);
    end
  endtask

  task automatic test_be_zero();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl;
    sel = 1'b0;
    xfer(1'b1, 32'h1008, 32'hFFFFFFFF, 4'h0, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(rw), er, oe, rd} !== {8'd1, 1'b0, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL wr_be0: got rw=%0d err=%b oerr=%b rdata=%h want 1 0 1 00000000", rw, er, oe, rd);
    end
    xfer(1'b0, 32'h1008, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rd_after_be0: got err=%b oerr=%b rdata=%h want 0 0 00000000", er, oe, rd);
    end
    xfer(1'b0, 32'h1000, 32'h0, 4'h0, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, oe, rd} !== {1'b0, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL rd_be0: got err=%b oerr=%b rdata=%h want 0 1 00000000", er, oe, rd);
    end
  endtask

  task automatic test_back_to_back();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl;
    sel = 1'b0;
    xfer(1'b1, 32'h1010, 32'h0F1E2D3C, 4'hF, gw, rw, rd, er, oe, gl);
    xfer(1'b0, 32'h1010, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), gl, rd} !== {8'd1, 8'd1, 1'b0, 32'h0F1E2D3C}) begin
      n_bad++;
      $display("FAIL b2b_read: got gw=%0d rw=%0d glitch=%b rdata=%h want 1 1 0 0f1e2d3c", gw, rw, gl, rd);
    end
  endtask

  task automatic test_latency();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl; bit seen;
    sel = 1'b1;
    xfer(1'b1, 32'h1010, 32'h12345678, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), er, oe, gl} !== {8'd4, 8'd4, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL slow_wr_timing: got gw=%0d rw=%0d err=%b oerr=%b glitch=%b want 4 4 0 0 0", gw, rw, er, oe, gl);
    end
    xfer(1'b0, 32'h1010, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), gl, rd} !== {8'd4, 8'd4, 1'b0, 32'h12345678}) begin
      n_bad++;
      $display("FAIL slow_rd: got gw=%0d rw=%0d glitch=%b rdata=%h want 4 4 0 12345678", gw, rw, gl, rd);
    end
    // abandoned request: req held for two sampled edges then withdrawn
    seen = 1'b0;
    drive(1'b1, 1'b1, 32'h1020, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    if (s_gnt || s_rv) seen = 1'b1;
    @(negedge clk);
    if (s_gnt || s_rv) seen = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (s_gnt || s_rv) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abandon_no_gnt: got activity=%b want 0", seen);
    end
    xfer(1'b0, 32'h1020, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), rd} !== {8'd4, 8'd4, 32'h0}) begin
      n_bad++;
      $display("FAIL abandon_no_write: got gw=%0d rw=%0d rdata=%h want 4 4 00000000", gw, rw, rd);
    end
  endtask

  task automatic test_reset_mid();
    int gw, rw; logic [31:0] rd; logic er, oe; bit gl; bit seen;
    int g;
    sel = 1'b1;
    seen = 1'b0;
    g = -1;
    drive(1'b1, 1'b1, 32'h1010, 32'h0BADF00D, 4'hF);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_gnt) begin g = k; break; end
    end
    drive(1'b0, 1'b1, 32'h1010, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({8'(g), s_gnt, s_rv, s_err, s_oerr, s_rdata} !== {8'd4, 36'd0}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got gw=%0d gnt=%b rv=%b err=%b oerr=%b rdata=%h want 4 0 0 0 0 00000000",
               g, s_gnt, s_rv, s_err, s_oerr, s_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_gnt || s_rv) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_no_rvalid: got activity=%b want 0", seen);
    end
    xfer(1'b0, 32'h1010, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({8'(gw), 8'(rw), rd} !== {8'd4, 8'd4, 32'h0}) begin
      n_bad++;
      $display("FAIL mid_reset_mem_cleared: got gw=%0d rw=%0d rdata=%h want 4 4 00000000", gw, rw, rd);
    end
    sel = 1'b0;
    xfer(1'b0, 32'h1004, 32'h0, 4'hF, gw, rw, rd, er, oe, gl);
    n_cmp++;
    if ({er, rd} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_clears_default: got err=%b rdata=%h want 0 00000000", er, rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_add = '0; d_wdata = '0; d_be = '0;
    s_req = 1'b0; s_we = 1'b0; s_add = '0; s_wdata = '0; s_be = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_partial_write();
    test_range();
    test_be_zero();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
